// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: valid/ready request channel, fixed
// programmable latency, valid/ready response channel carrying rdata/err.
module data_mem_responder #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

   if (WAIT_CYCLES > 15) begin : g_bad_wait
      $error("data_mem_responder: WAIT_CYCLES must be in 0..15");
   end
   if (DEPTH < 2 || DEPTH > 32'h4000_0000) begin : g_bad_depth
      $error("data_mem_responder: DEPTH out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH];

   logic          w_accept;
   logic          w_commit;
   logic          w_err;
   logic [IW-1:0] w_idx;

   assign w_err = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH));
   assign w_idx = r_addr[IW+1:2];

   // WAIT always lasts WAIT_CYCLES+1 cycles (commit on counter==0), so a
   // response is visible WAIT_CYCLES+1 edges after accept, even for zero wait.
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      busy       = 1'b1;
      w_accept   = 1'b0;
      w_commit   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            w_accept  = req_valid;
            if (req_valid) w_next = ST_WAIT;
         end
         ST_WAIT: begin
            w_commit = (r_cnt == 4'd0);
            if (r_cnt == 4'd0) w_next = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= LP_WAIT;
         end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_we) ? '0 : r_mem[w_idx];
         end
      end
   end

   // RAM contents survive reset; a commit coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (!reset && w_commit && r_we && !w_err) begin
         r_mem[w_idx] <= r_wdata;
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule
